// File: rtl/risc_pkg.sv
// Shared types and widths for the RISC pipeline stages.
// Exports mem_state_t, ex_mem_t and the DW/AW/RW constants.
package risc_pkg;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int RW = 3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } mem_state_t;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] store;
    logic          mem_read;
    logic          mem_write;
    logic          reg_write;
    logic          mem_to_reg;
    logic [RW-1:0] rd;
  } ex_mem_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response handshake bundle.
// master: req_valid/we/addr/wdata out; ready, rsp_valid, rdata in.
interface mem_stage_if;
  import risc_pkg::*;

  logic          dmem_req_valid;
  logic          dmem_req_ready;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_rsp_valid;
  logic [DW-1:0] dmem_rdata;

  modport master (
    output dmem_req_valid,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_req_ready,
    input  dmem_rsp_valid,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req_valid,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_req_ready,
    output dmem_rsp_valid,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_stage_wb_reg.sv
// MEM/WB pipeline register: bubble insert, R0 write suppression.
// Ports: clk, rst_n, bubble, reg_write/rd/data in; wb_* out.
module mem_wb_reg
  import risc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bubble,
  input  logic          reg_write,
  input  logic [RW-1:0] rd,
  input  logic [DW-1:0] data,
  output logic          wb_valid,
  output logic          wb_reg_write,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else if (bubble) begin
      // rd/data hold their last value so the forwarding
      // source does not toggle on bubbles
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
    end else begin
      wb_valid     <= 1'b1;
      wb_reg_write <= reg_write & (|rd);
      wb_rd        <= rd;
      wb_data      <= data;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM consumer, dmem FSM, MEM/WB register.
// Ports: clk, rst_n, in_*, stall, dmem (master), wb_*.
module mem_stage
  import risc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_alu,
  input  logic [DW-1:0] in_store,
  input  logic          in_mem_read,
  input  logic          in_mem_write,
  input  logic          in_reg_write,
  input  logic          in_mem_to_reg,
  input  logic [RW-1:0] in_rd,
  output logic          stall,
  mem_stage_if.master   dmem,
  output logic          wb_valid,
  output logic          wb_reg_write,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data
);

  ex_mem_t       ex;
  mem_state_t    state;
  logic [RW-1:0] req_rd;
  logic          req_rw;
  logic          req_m2r;
  logic          memop;
  logic          bubble;
  logic          nx_rw;
  logic [RW-1:0] nx_rd;
  logic [DW-1:0] nx_data;

  assign ex = '{
    alu:        in_alu,
    store:      in_store,
    mem_read:   in_mem_read,
    mem_write:  in_mem_write,
    reg_write:  in_reg_write,
    mem_to_reg: in_mem_to_reg,
    rd:         in_rd
  };

  assign memop = ex.mem_read | ex.mem_write;

  always_comb begin
    stall   = 1'b0;
    bubble  = 1'b1;
    nx_rw   = 1'b0;
    nx_rd   = req_rd;
    nx_data = dmem.dmem_wdata;
    unique case (1'b1)
      (state == IDLE): begin
        stall = in_valid & memop;
        if (in_valid && !memop) begin
          bubble  = 1'b0;
          nx_rw   = ex.reg_write;
          nx_rd   = ex.rd;
          nx_data = ex.alu;
        end
      end
      (state == REQ): begin
        stall = !(dmem.dmem_we & dmem.dmem_req_ready);
        if (dmem.dmem_we && dmem.dmem_req_ready)
          bubble = 1'b0;
      end
      (state == RESP): begin
        stall = !dmem.dmem_rsp_valid;
        if (dmem.dmem_rsp_valid) begin
          bubble  = 1'b0;
          nx_rw   = req_rw;
          nx_data = req_m2r ? dmem.dmem_rdata
                            : DW'(dmem.dmem_addr);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      dmem.dmem_req_valid <= 1'b0;
      dmem.dmem_we        <= 1'b0;
      dmem.dmem_addr      <= '0;
      dmem.dmem_wdata     <= '0;
      req_rd              <= '0;
      req_rw              <= 1'b0;
      req_m2r             <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && memop) begin
            dmem.dmem_req_valid <= 1'b1;
            // read+write together resolves to a store
            dmem.dmem_we        <= ex.mem_write;
            dmem.dmem_addr      <= ex.alu[AW-1:0];
            dmem.dmem_wdata     <= ex.store;
            req_rd              <= ex.rd;
            req_rw              <= ex.reg_write & ~ex.mem_write;
            req_m2r             <= ex.mem_to_reg;
            state               <= REQ;
          end
        end
        REQ: begin
          if (dmem.dmem_req_ready) begin
            dmem.dmem_req_valid <= 1'b0;
            state <= dmem.dmem_we ? IDLE : RESP;
          end
        end
        RESP: begin
          if (dmem.dmem_rsp_valid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_wb_reg u_wb (
    .clk          (clk),
    .rst_n        (rst_n),
    .bubble       (bubble),
    .reg_write    (nx_rw),
    .rd           (nx_rd),
    .data         (nx_data),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage.
// Vector table for single ops plus hand sequences.
module tb_mem_stage;
  import risc_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_alu = '0;
  logic [DW-1:0] in_store = '0;
  logic          in_mem_read = 1'b0;
  logic          in_mem_write = 1'b0;
  logic          in_reg_write = 1'b0;
  logic          in_mem_to_reg = 1'b0;
  logic [RW-1:0] in_rd = '0;
  logic          stall;
  logic          wb_valid;
  logic          wb_reg_write;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  mem_stage_if dmem ();

  mem_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_alu        (in_alu),
    .in_store      (in_store),
    .in_mem_read   (in_mem_read),
    .in_mem_write  (in_mem_write),
    .in_reg_write  (in_reg_write),
    .in_mem_to_reg (in_mem_to_reg),
    .in_rd         (in_rd),
    .stall         (stall),
    .dmem          (dmem),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  typedef struct {
    logic        valid;
    logic        mrd;
    logic        mwr;
    logic        rw;
    logic [2:0]  rd;
    logic [15:0] alu;
    logic [15:0] store;
    logic [15:0] rdata;
    int          rdy_dly;
    int          rsp_dly;
    int          exp_stall;
    logic        exp_valid;
    logic        exp_rw;
    logic        exp_we;
    logic        chk_data;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  task automatic present(logic v, logic mr, logic mw, logic rw,
                         logic [2:0] rd, logic [15:0] a,
                         logic [15:0] s);
    in_valid      = v;
    in_mem_read   = mr;
    in_mem_write  = mw;
    in_reg_write  = rw;
    in_mem_to_reg = mr;
    in_rd         = rd;
    in_alu        = a;
    in_store      = s;
  endtask

  task automatic run_vec(int idx, vec_t v);
    int  since = 0;
    int  waited = 0;
    int  stalls = 0;
    int  bubbles = 0;
    int  ferr = 0;
    bit  hs = 0;
    bit  done = 0;
    bit  req_seen = 0;
    string tag;
    tag = $sformatf("v%0d", idx);
    present(v.valid, v.mrd, v.mwr, v.rw, v.rd, v.alu, v.store);
    dmem.dmem_rdata = v.rdata;
    for (int c = 0; c < 40 && !done; c++) begin
      if (hs) since++;
      dmem.dmem_rsp_valid = hs && (since == v.rsp_dly);
      dmem.dmem_req_ready = 1'b0;
      if (dmem.dmem_req_valid) begin
        req_seen = 1;
        if (dmem.dmem_addr !== v.alu ||
            dmem.dmem_we !== v.exp_we ||
            (v.exp_we && dmem.dmem_wdata !== v.store))
          ferr++;
        if (waited < v.rdy_dly) waited++;
        else begin
          dmem.dmem_req_ready = 1'b1;
          hs = 1;
        end
      end
      #1;
      if (stall) stalls++;
      else done = 1;
      @(posedge clk);
      #1;
      if (!done && !wb_valid) bubbles++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_rsp_valid = 1'b0;
    chk({tag, " finished"}, 32'(done), 32'd1);
    chk({tag, " stall_cycles"}, stalls, v.exp_stall);
    chk({tag, " bubbles"}, bubbles, v.exp_stall);
    chk({tag, " req_fields"}, ferr, 0);
    chk({tag, " req_seen"}, 32'(req_seen),
        32'(v.valid & (v.mrd | v.mwr)));
    chk({tag, " req_dropped"}, 32'(dmem.dmem_req_valid), 0);
    chk({tag, " wb_valid"}, 32'(wb_valid), 32'(v.exp_valid));
    chk({tag, " wb_reg_write"}, 32'(wb_reg_write), 32'(v.exp_rw));
    if (v.exp_valid)
      chk({tag, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
    if (v.chk_data)
      chk({tag, " wb_data"}, 32'(wb_data), 32'(v.exp_data));
  endtask

  initial begin
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_rsp_valid = 1'b0;
    dmem.dmem_rdata     = '0;

    vecs[0] = '{1,0,0,1,3,16'h1234,0,0,0,0, 0,1,1,0,1,16'h1234};
    vecs[1] = '{1,0,0,1,0,16'h5555,0,0,0,0, 0,1,0,0,1,16'h5555};
    vecs[2] = '{1,0,1,0,1,16'h0040,16'hBEEF,0,0,0, 1,1,0,1,0,0};
    vecs[3] = '{1,1,0,1,5,16'h0100,0,16'hCAFE,3,2,
                6,1,1,0,1,16'hCAFE};
    vecs[4] = '{1,1,0,1,0,16'h0104,0,16'h1111,0,1,
                2,1,0,0,1,16'h1111};
    vecs[5] = '{1,1,1,1,4,16'h0022,16'h7777,16'h9999,0,1,
                1,1,0,1,0,0};
    vecs[6] = '{1,0,1,0,2,16'h0050,16'h0A0A,0,2,0, 3,1,0,1,0,0};
    vecs[7] = '{1,1,0,1,7,16'h0200,0,16'h4321,0,1,
                2,1,1,0,1,16'h4321};
    vecs[8] = '{0,1,0,1,2,16'h0300,0,0,0,0, 0,0,0,0,0,0};
    vecs[9] = '{1,0,0,0,7,16'hFFFF,0,0,0,0, 0,1,0,0,1,16'hFFFF};

    // reset state
    #1;
    chk("rst state", 32'(dut.state), 32'(IDLE));
    chk("rst req_valid", 32'(dmem.dmem_req_valid), 0);
    chk("rst we", 32'(dmem.dmem_we), 0);
    chk("rst addr", 32'(dmem.dmem_addr), 0);
    chk("rst wdata", 32'(dmem.dmem_wdata), 0);
    chk("rst wb_valid", 32'(wb_valid), 0);
    chk("rst wb_reg_write", 32'(wb_reg_write), 0);
    chk("rst wb_rd", 32'(wb_rd), 0);
    chk("rst wb_data", 32'(wb_data), 0);
    chk("rst stall", 32'(stall), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // back-to-back: load then ALU op held behind it
    present(1, 1, 0, 1, 3'd6, 16'h0200, 16'h0);
    dmem.dmem_rdata = 16'hAAAA;
    #1 chk("b2b c0 stall", 32'(stall), 1);
    @(negedge clk);
    dmem.dmem_req_ready = 1'b1;
    #1 chk("b2b c1 stall", 32'(stall), 1);
    chk("b2b c1 req", 32'(dmem.dmem_req_valid), 1);
    @(negedge clk);
    dmem.dmem_req_ready = 1'b0;
    dmem.dmem_rsp_valid = 1'b1;
    #1 chk("b2b c2 stall", 32'(stall), 0);
    @(negedge clk);
    dmem.dmem_rsp_valid = 1'b0;
    present(1, 0, 0, 1, 3'd2, 16'h0BBB, 16'h0);
    #1 chk("b2b ld wb_valid", 32'(wb_valid), 1);
    chk("b2b ld wb_data", 32'(wb_data), 32'hAAAA);
    chk("b2b ld wb_rd", 32'(wb_rd), 6);
    chk("b2b alu stall", 32'(stall), 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("b2b alu wb_valid", 32'(wb_valid), 1);
    chk("b2b alu wb_data", 32'(wb_data), 32'h0BBB);
    chk("b2b alu wb_rd", 32'(wb_rd), 2);
    chk("b2b alu wb_rw", 32'(wb_reg_write), 1);
    @(negedge clk);

    // reset while in REQ: request drops asynchronously
    present(1, 1, 0, 1, 3'd1, 16'h0400, 16'h0);
    @(negedge clk);
    chk("rreq req_valid", 32'(dmem.dmem_req_valid), 1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1 chk("rreq async drop", 32'(dmem.dmem_req_valid), 0);
    chk("rreq state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset while in RESP: late response discarded
    present(1, 1, 0, 1, 3'd1, 16'h0400, 16'h0);
    @(negedge clk);
    dmem.dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem.dmem_req_ready = 1'b0;
    #1 chk("rrsp state", 32'(dut.state), 32'(RESP));
    chk("rrsp stall", 32'(stall), 1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1 chk("rrsp rst state", 32'(dut.state), 32'(IDLE));
    dmem.dmem_rsp_valid = 1'b1;
    dmem.dmem_rdata = 16'hDEAD;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rrsp late wb_valid", 32'(wb_valid), 0);
    chk("rrsp late stall", 32'(stall), 0);
    chk("rrsp late state", 32'(dut.state), 32'(IDLE));
    chk("rrsp late req", 32'(dmem.dmem_req_valid), 0);
    dmem.dmem_rsp_valid = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline memory stage that sits directly downstream of the execute stage: it consumes the EX/MEM pipeline register (ALU result, store data, control bits), performs data-memory loads and stores over a valid/ready request and valid response handshake, and holds the MEM/WB pipeline register. It stalls the upstream pipeline while a memory access is outstanding. It also supplies the MEM/WB write-back value that the execute stage's forwarding mux selects with code 01.

## Interface
- `DW`, 16: data width.
- `AW`, 16: data-memory word-address width.
- `RW`, 3: register index width (8 architectural registers).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: EX/MEM register holds a valid instruction.
- `in_alu` in DW: ALU result; the load/store word address for memory ops.
- `in_store` in DW: store data, already forwarded.
- `in_mem_read`, `in_mem_write`, `in_reg_write`, `in_mem_to_reg` in 1 each: control bits.
- `in_rd` in RW: destination register.
- `stall` out 1: upstream must hold EX/MEM contents and freeze.
- `dmem_req_valid` out 1: request valid.
- `dmem_req_ready` in 1: request accepted when both valid and ready are high.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out AW: word address.
- `dmem_wdata` out DW: store data.
- `dmem_rsp_valid` in 1: load data valid.
- `dmem_rdata` in DW: load data.
- `wb_valid`, `wb_reg_write` out 1 each: MEM/WB register contents.
- `wb_rd` out RW: MEM/WB destination register.
- `wb_data` out DW: MEM/WB data; also the forwarding `mem_wb_data` source.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE, non-memory op (`in_valid` with `mem_read`=0 and `mem_write`=0):
  - MEM/WB loads `wb_data`=`in_alu`, `wb_rd`, and `wb_reg_write`.
  - `stall`=0.
- IDLE, memory op:
  - `stall`=1.
  - Capture addr, wdata, we, rd, and reg_write into the request registers.
  - Move to REQ.
  - MEM/WB loads a bubble (`wb_valid`=0, `wb_reg_write`=0).
- REQ:
  - `dmem_req_valid`=1; addr, wdata, and we are held stable until the handshake.
  - On handshake for a store: completion. `stall`=0 this cycle; MEM/WB loads `wb_valid`=1 with `wb_reg_write`=0; go to IDLE.
  - On handshake for a load: go to RESP; `stall` stays 1.
- RESP:
  - Wait for `dmem_rsp_valid`. On it: `stall`=0 this cycle; MEM/WB loads `wb_data`=`dmem_rdata` with rd and reg_write; go to IDLE.
- Every stalled cycle loads a bubble into MEM/WB.
- `stall` = (IDLE & `in_valid` & memop) | (REQ & !(store & `dmem_req_ready`)) | (RESP & !`dmem_rsp_valid`).
- `in_mem_read` and `in_mem_write` both high: treated as a store; `wb_reg_write` forced 0.
- `wb_reg_write` is forced 0 whenever `wb_rd`=0 (R0 hardwired zero).
- `dmem_rsp_valid` in IDLE or REQ is ignored. No response is tracked after a reset.
- `in_valid`=0 in IDLE loads a bubble; `stall`=0.

## Timing
- Reset values:
  - state=IDLE.
  - `dmem_req_valid`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0.
  - `wb_valid`=0, `wb_reg_write`=0, `wb_rd`=0, `wb_data`=0.
  - `stall` then evaluates to 0 unless a memory op is presented.
- Non-memory op presented in cycle N: MEM/WB valid at N+1.
- Store presented at N with ready held high: request at N+1 and handshake then; MEM/WB at N+2; stall high in N only.
- Load presented at N, ready high, response at N+2: stall high N..N+1, low N+2; `wb_data` valid at N+3.
- Each cycle of ready low adds one cycle; each cycle of response delay adds one cycle.
- `dmem_*` request outputs are registered. `stall` is combinational from state and `in_*`, `dmem_req_ready`, `dmem_rsp_valid`.
- Reset asserted mid-access (REQ or RESP): request outputs drop asynchronously, FSM returns to IDLE, and any late response is discarded.

## Structure
- Shared package `risc_pkg`:
  - `mem_state_t` enum {IDLE, REQ, RESP}.
  - Constants `DW`=16 and `RW`=3.
  - Struct `ex_mem_t` {alu, store, mem_read, mem_write, reg_write, mem_to_reg, rd}.
- One sub-module `mem_wb_reg`: the MEM/WB register with async reset, a bubble-insert input, and R0 write suppression.
- The FSM and request registers live in `mem_stage`.

## Test plan
- Reset mid-access: load in RESP, pulse `rst_n` low, then `dmem_rsp_valid`=1 -> state IDLE, `dmem_req_valid`=0, `wb_valid`=0, response ignored.
- ALU op `in_alu`=0x1234, rd=3, reg_write=1 -> next cycle `wb_data`=0x1234, `wb_rd`=3, `wb_reg_write`=1, `stall` never high.
- Store addr 0x0040, data 0xBEEF, ready high:
  - cycle N+1: `dmem_req_valid`=1, `dmem_we`=1, `dmem_addr`=0x0040, `dmem_wdata`=0xBEEF.
  - N+2: `wb_valid`=1, `wb_reg_write`=0.
  - `stall` high only in N.
- Load addr 0x0100, ready low for 3 cycles, response 0xCAFE two cycles after handshake, rd=5:
  - request fields stable throughout.
  - `stall` high until the response cycle.
  - `wb_data`=0xCAFE, `wb_rd`=5 one cycle after the response.
  - One bubble per stalled cycle.
- Back-to-back: load immediately followed by an ALU op held during the stall -> the ALU result reaches MEM/WB exactly one cycle after the load's write-back.
- Load with rd=0 -> `wb_reg_write`=0. Load with read and write both high -> treated as store, `dmem_we`=1.
